// File: rtl/mar_ram.sv
// -----------------------------------------------------------------------------
// mar_ram : SAP-style memory stage
//
// Purpose:
//   A 4-bit memory address register (MAR) in front of a 16x8 register-file
//   RAM. In run mode the MAR is loaded from the bus, the RAM is written from
//   the bus at ram[MAR], and ram[MAR] is read combinationally onto bus_out.
//   A byte-stream programming FSM (IDLE/LOAD/DONE) fills the RAM from chip
//   pins before run.
//
// Configuration macro:
//   PROG_CHECKSUM_EN - when defined, prog_checksum is a registered mod-256 sum
//                      of the bytes accepted in the current programming
//                      session. When undefined, prog_checksum is tied to zero.
//
// Ports:
//   clk           in   system clock, posedge
//   rst_n         in   asynchronous active-low reset
//   bus_in        in   [DATA_W] bus value from other blocks
//   bus_out       out  [DATA_W] ram[MAR], zero-latency read
//   bus_oe        out  drive enable for bus_out (ce, run mode only)
//   lm            in   load MAR from bus_in[ADDR_W-1:0]
//   ce            in   RAM output enable
//   lr            in   write bus_in into ram[MAR]
//   prog_mode     in   programming mode request
//   prog_valid    in   prog_data holds a byte
//   prog_data     in   [DATA_W] byte to program
//   prog_ready    out  FSM accepts a byte this cycle (registered)
//   prog_done     out  all DEPTH words programmed (registered)
//   prog_checksum out  [DATA_W] programming checksum
//   mar_q         out  [ADDR_W] current MAR
// -----------------------------------------------------------------------------
module mar_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              lm,
  input  logic              ce,
  input  logic              lr,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [DATA_W-1:0] prog_checksum,
  output logic [ADDR_W-1:0] mar_q
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mar_d;
  logic [ADDR_W-1:0]   prog_addr_q, prog_addr_d;
  logic                prog_ready_d, prog_done_d;
  logic [DATA_W-1:0]   ram_q [DEPTH];

  logic                run_s;
  logic                accept_s;
  logic                we_s;
  logic [ADDR_W-1:0]   waddr_s;
  logic [DATA_W-1:0]   wdata_s;

  // Run controls only act in IDLE; a byte is accepted only while the session
  // is still requested (dropping prog_mode aborts without a final write).
  assign run_s    = (state_q == ST_IDLE);
  assign accept_s = (state_q == ST_LOAD) && prog_ready && prog_valid && prog_mode;

  // Combinational read of the addressed word; valid regardless of ce.
  assign bus_out = ram_q[mar_q];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (prog_mode) state_d = ST_LOAD;
        else           state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (!prog_mode)                                 state_d = ST_IDLE;
        else if (accept_s && (prog_addr_q == LAST_ADDR)) state_d = ST_DONE;
        else                                            state_d = ST_LOAD;
      end
      ST_DONE: begin
        if (!prog_mode) state_d = ST_IDLE;
        else            state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: bus drive is combinational, ready/done are pre-decoded from
  // the next state so their registers line up with the state register.
  always_comb begin
    bus_oe       = ce && run_s;
    prog_ready_d = (state_d == ST_LOAD);
    prog_done_d  = (state_d == ST_DONE);
  end

  // Registered programming status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_ready <= 1'b0;
      prog_done  <= 1'b0;
    end else begin
      prog_ready <= prog_ready_d;
      prog_done  <= prog_done_d;
    end
  end

  // MAR and programming address next-state.
  always_comb begin
    mar_d       = mar_q;
    prog_addr_d = prog_addr_q;
    if (run_s && lm) begin
      mar_d = bus_in[ADDR_W-1:0];
    end else begin
      mar_d = mar_q;
    end
    if (run_s && prog_mode) begin
      prog_addr_d = {ADDR_W{1'b0}};
    end else if (accept_s) begin
      // Natural wrap to 0 after the last word.
      prog_addr_d = prog_addr_q + ADDR_ONE;
    end else begin
      prog_addr_d = prog_addr_q;
    end
  end

  // MAR and programming address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_q       <= {ADDR_W{1'b0}};
      prog_addr_q <= {ADDR_W{1'b0}};
    end else begin
      mar_q       <= mar_d;
      prog_addr_q <= prog_addr_d;
    end
  end

  // Single RAM write port shared by run-mode lr and programming bytes; the
  // run-mode write uses the MAR value from before this edge.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = {ADDR_W{1'b0}};
    wdata_s = {DATA_W{1'b0}};
    if (run_s && lr) begin
      we_s    = 1'b1;
      waddr_s = mar_q;
      wdata_s = bus_in;
    end else if (accept_s) begin
      we_s    = 1'b1;
      waddr_s = prog_addr_q;
      wdata_s = prog_data;
    end else begin
      we_s    = 1'b0;
    end
  end

  // RAM storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_q[i] <= {DATA_W{1'b0}};
      end
    end else if (we_s) begin
      ram_q[waddr_s] <= wdata_s;
    end
  end

`ifdef PROG_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Checksum next-state: cleared on session entry, summed on accepted bytes.
  always_comb begin
    csum_d = csum_q;
    if (run_s && prog_mode) begin
      csum_d = {DATA_W{1'b0}};
    end else if (accept_s) begin
      csum_d = csum_q + prog_data;
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= {DATA_W{1'b0}};
    end else begin
      csum_q <= csum_d;
    end
  end

  assign prog_checksum = csum_q;
`else
  assign prog_checksum = {DATA_W{1'b0}};
`endif

endmodule

// File: doc/mar_ram.md
Name: mar_ram

Overview:
- SAP-style memory stage: 4-bit memory address register (MAR) plus 16x8 register-file RAM.
- Sits downstream of the program counter. The MAR is loaded from the bus (PC output during fetch, operand during execute). RAM drives the bus toward the instruction register and accumulator path.
- Includes a byte-stream programming FSM so the program can be loaded from chip pins before run.

Parameters:
- ADDR_W, 4, MAR/address width.
- DATA_W, 8, RAM word and bus width.
- DEPTH, 2**ADDR_W, number of RAM words (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- bus_in  input  DATA_W  bus value driven by other blocks.
- bus_out  output  DATA_W  RAM read data toward bus.
- bus_oe  output  1  high when bus_out must drive the bus.
- lm  input  1  load MAR from bus_in[ADDR_W-1:0].
- ce  input  1  RAM output enable onto bus.
- lr  input  1  write bus_in into ram[MAR].
- prog_mode  input  1  high selects programming mode.
- prog_valid  input  1  prog_data holds a byte.
- prog_data  input  DATA_W  byte to program.
- prog_ready  output  1  FSM accepts a byte this cycle.
- prog_done  output  1  all DEPTH words programmed.
- prog_checksum  output  DATA_W  running checksum (see Optional Feature).
- mar_q  output  ADDR_W  current MAR, for debug pins.

Behaviour:
- Reset (async on rst_n low): MAR=0, all RAM words=0x00, FSM=IDLE, prog_addr=0, prog_ready=0, prog_done=0, bus_oe=0, prog_checksum=0.
- Run mode (FSM=IDLE):
  - lm: MAR<=bus_in[ADDR_W-1:0] at posedge; bus_in[7:4] ignored.
  - lr: ram[MAR]<=bus_in at posedge.
  - lm and lr in the same cycle: write uses the pre-update MAR; MAR updates in the same edge.
  - bus_out=ram[MAR], combinational, zero-latency read. bus_out is valid regardless of ce.
  - bus_oe=ce (combinational).
  - ce and lr together: write happens; bus_out shows the old word until the edge.
- FSM states IDLE, LOAD, DONE:
  - IDLE -> LOAD when prog_mode=1 at posedge; prog_addr<=0 and checksum<=0 on entry.
  - LOAD: prog_ready=1. On prog_valid and prog_ready: ram[prog_addr]<=prog_data, prog_addr<=prog_addr+1.
  - LOAD -> DONE on the accepted write at prog_addr=DEPTH-1. prog_addr wraps to 0; no further writes.
  - LOAD -> IDLE if prog_mode=0 (abort). Already-written words are kept; unwritten words keep prior contents.
  - DONE: prog_done=1, prog_ready=0; prog_valid ignored. DONE -> IDLE when prog_mode=0.
- In LOAD and DONE: lm, lr, ce ignored; bus_oe=0; MAR held.
- prog_ready and prog_done are registered outputs, derived from state.
- Async reset mid-LOAD returns to IDLE with RAM cleared.

Optional Feature:
- Macro PROG_CHECKSUM_EN.
- Defined: prog_checksum is an 8-bit register.
  - Cleared on IDLE->LOAD.
  - On each accepted programming byte: checksum<=checksum+prog_data (mod 256).
  - Held in DONE and IDLE until the next LOAD entry.
  - Run-mode lr writes do not affect it.
- Not defined: prog_checksum tied to 0; no register is synthesised.

Test Plan:
- Reset then lm with bus_in=0xA7 -> mar_q=7. ce=1 -> bus_oe=1, bus_out=0x00 (cleared RAM).
- prog_mode=1, stream 0x10..0x1F with prog_valid held high:
  - 16 writes on consecutive cycles, then prog_done=1, prog_ready=0.
  - prog_mode=0 -> IDLE.
  - With PROG_CHECKSUM_EN: checksum=0x78.
- After programming, lm with bus_in=0x05 then ce=1 -> bus_out=0x15. In the same cycle, lr=1 with bus_in=0xEE -> next cycle bus_out=0xEE at address 5.
- lm=1 (bus_in=0x03) and lr=1 in the same cycle with MAR=9 -> ram[9]=0x03, MAR=3, ram[3] unchanged.
- Abort: prog_mode=1, write 3 bytes 0xAA, 0xBB, 0xCC, drop prog_mode -> IDLE. ram[0..2]=AA,BB,CC; ram[3] retains its old value. lm/ce in the same cycle as abort are ignored until IDLE.
- During LOAD, assert ce=1, lr=1, lm=1 -> bus_oe=0, MAR and RAM unchanged by the run controls. Assert rst_n=0 mid-LOAD -> immediate IDLE, prog_ready=0, all RAM 0x00.
